// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/instruction widths, reset vector and the
// {pc, inst} record carried through the fetch prefetch queue.
package cpu_pkg;

    localparam int          ADDR_W       = 32;
    localparam int          INST_W       = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with push/pop/flush; the head entry
// is read combinationally so a push is visible on the very next cycle.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               wr_entry,
    output fetch_entry_t               rd_entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int QCNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == QCNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty && !flush;
    assign do_push  = push && !flush && (!full || do_pop);
    assign rd_entry = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy are controlled.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop) begin
                count <= count + QCNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - QCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, fills the prefetch queue from the
// combinational instruction memory and handles execute redirects.
module inst_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_en,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_inst,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc_plus4,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    logic [31:0]                fetch_pc;
    logic                       push;
    logic                       pop;
    fetch_entry_t               wr_entry;
    fetch_entry_t               head;
    fetch_entry_t               last_head;
    fetch_entry_t               shown;
    logic [$clog2(DEPTH+1)-1:0] q_count;
    logic                       q_full;
    logic                       q_empty;

    assign imem_addr     = fetch_pc;
    assign wr_entry.pc   = fetch_pc;
    assign wr_entry.inst = imem_inst;

    assign out_valid = !q_empty;
    assign pop       = out_valid && out_ready;
    assign push      = fetch_en && !redirect && (!q_full || pop);

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Outputs freeze on the last presented head whenever the queue is empty.
    assign shown        = out_valid ? head : last_head;
    assign out_pc       = shown.pc;
    assign out_inst     = shown.inst;
    assign out_pc_plus4 = shown.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_head.pc   <= 32'h0000_0000;
            last_head.inst <= NOP;
        end else if (out_valid) begin
            last_head <= head;
        end
    end

    // Redirect beats push; PC increment wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            misalign_err <= 1'b0;
            fetch_cnt    <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) fetch_cnt <= fetch_cnt + CNT_W'(1);
        end
    end

    a_queue_occupancy: assert property (@(posedge clk) disable iff (rst)
        (int'(q_count) <= DEPTH) && (q_full == (int'(q_count) == DEPTH)));

endmodule
